// File: rtl/shadow_pkg.sv
// Shared types for the shadow chain collector: FSM encoding and FIFO entry layout.
package shadow_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DUMP  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_TRAIL = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   localparam int BIT_CNT_W = 32;

   // The trailer flag sits directly above the data bits of each FIFO entry.
   function automatic int last_pos(input int word_w);
      return word_w;
   endfunction

endpackage

// File: rtl/shadow_word_fifo.sv
// Word buffer for the collector: combinational head, registered full/empty flags.
module shadow_word_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);

   // A push into a full buffer succeeds when the head leaves in the same cycle.
   assign rd_ok = pop && !empty;
   assign wr_ok = push && (!full || rd_ok);

   assign rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/shadow_chain_collector.sv
// Collects a serial shadow-chain dump LSB-first into words, then appends a
// trailer word carrying the total bit count.
module shadow_chain_collector
   import shadow_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              sh_clk,
   input  logic              sh_rst,
   input  logic              start,
   output logic              dump_en,
   input  logic              ch_in,
   input  logic              ch_in_vld,
   input  logic              ch_in_done,
   output logic [WORD_W-1:0] word_data,
   output logic              word_vld,
   input  logic              word_rdy,
   output logic              word_last,
   output logic              busy,
   output logic              overflow
);

   localparam int AW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int EW = WORD_W + 1;
   localparam int LP = last_pos(WORD_W);

   state_e                 state;
   logic [WORD_W-1:0]      asm_q;
   logic [WORD_W-1:0]      asm_nxt;
   logic [AW-1:0]          asm_cnt;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   word_done;

   logic                   push;
   logic [WORD_W-1:0]      push_data;
   logic                   push_last;
   logic [EW-1:0]          fifo_wdata;
   logic [EW-1:0]          fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   can_push;

   assign busy      = (state != ST_IDLE);
   assign dump_en   = (state == ST_DUMP) && !fifo_full;
   assign word_vld  = !fifo_empty;
   assign word_data = fifo_head[WORD_W-1:0];
   assign word_last = fifo_head[LP];

   // Full is only a blocker when the head is not leaving this cycle.
   assign can_push  = !fifo_full || word_rdy;
   assign word_done = (asm_cnt == AW'(WORD_W - 1));

   always_comb begin
      asm_nxt          = asm_q;
      asm_nxt[asm_cnt] = ch_in;
   end

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      push_last = 1'b0;
      case (state)
         ST_DUMP: begin
            if (ch_in_vld && word_done) begin
               push      = 1'b1;
               push_data = asm_nxt;
            end
         end
         ST_FLUSH: begin
            if (asm_cnt != '0 && can_push) begin
               push      = 1'b1;
               push_data = asm_q;
            end
         end
         ST_TRAIL: begin
            if (can_push) begin
               push      = 1'b1;
               push_data = WORD_W'(bit_cnt);
               push_last = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      fifo_wdata     = EW'(push_data);
      fifo_wdata[LP] = push_last;
   end

   always_ff @(posedge sh_clk) begin
      if (sh_rst) begin
         state    <= ST_IDLE;
         asm_q    <= '0;
         asm_cnt  <= '0;
         bit_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_DUMP;
                  asm_q    <= '0;
                  asm_cnt  <= '0;
                  bit_cnt  <= '0;
                  overflow <= 1'b0;
               end
            end
            ST_DUMP: begin
               // A bit arriving with done is still taken before leaving DUMP.
               if (ch_in_vld) begin
                  if (bit_cnt != '1)
                     bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                  if (word_done) begin
                     asm_q   <= '0;
                     asm_cnt <= '0;
                     if (!can_push)
                        overflow <= 1'b1;
                  end else begin
                     asm_q   <= asm_nxt;
                     asm_cnt <= asm_cnt + AW'(1);
                  end
               end
               if (ch_in_done)
                  state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (asm_cnt == '0) begin
                  state <= ST_TRAIL;
               end else if (can_push) begin
                  state   <= ST_TRAIL;
                  asm_q   <= '0;
                  asm_cnt <= '0;
               end
            end
            ST_TRAIL: begin
               if (can_push)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (fifo_empty)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   shadow_word_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sh_clk),
      .rst   (sh_rst),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (word_rdy),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_shadow_chain_collector.sv
// Randomized bench for shadow_chain_collector with a word-list reference model.
module tb_shadow_chain_collector;

   localparam int WORD_W = 32;
   localparam int DEPTH  = 8;

   logic              sh_clk;
   logic              sh_rst;
   logic              start;
   logic              dump_en;
   logic              ch_in;
   logic              ch_in_vld;
   logic              ch_in_done;
   logic [WORD_W-1:0] word_data;
   logic              word_vld;
   logic              word_rdy;
   logic              word_last;
   logic              busy;
   logic              overflow;

   int chk_cnt = 0;
   int err_cnt = 0;
   bit rdy_hold;
   bit rdy_rand;
   logic [WORD_W:0] got[$];

   shadow_chain_collector #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH)) dut (
      .sh_clk     (sh_clk),
      .sh_rst     (sh_rst),
      .start      (start),
      .dump_en    (dump_en),
      .ch_in      (ch_in),
      .ch_in_vld  (ch_in_vld),
      .ch_in_done (ch_in_done),
      .word_data  (word_data),
      .word_vld   (word_vld),
      .word_rdy   (word_rdy),
      .word_last  (word_last),
      .busy       (busy),
      .overflow   (overflow)
   );

   initial sh_clk = 1'b0;
   always #5 sh_clk = ~sh_clk;

   task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      chk_cnt++;
      if (got_v !== exp_v) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
      end
   endtask

   // Consumer: collect every accepted head word.
   always @(negedge sh_clk)
      if (!sh_rst && word_vld && word_rdy)
         got.push_back({word_last, word_data});

   initial begin
      word_rdy = 1'b0;
      forever begin
         @(posedge sh_clk);
         #1;
         word_rdy = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(1)) : 1'b1);
      end
   end

   // Source answers dump_en with one cycle of latency unless ign_en is set.
   task automatic run_dump(input int nbits, input int pat, input bit ign_en, input int done_gap,
                           input int vld_pct, input int rel_after, input int abort_at,
                           input int busy_start_at, input bit hold);
      bit bq[$];
      logic [WORD_W:0] exp[$];
      logic [WORD_W-1:0] wv;
      int sent, cyc, stall_cyc, nfull, keep;
      bit en_prev, stalled;
      got.delete();
      for (int i = 0; i < nbits; i++)
         case (pat)
            1:       bq.push_back(i % 2 == 0);
            2:       bq.push_back(1'b1);
            default: bq.push_back(1'($urandom_range(1)));
         endcase
      rdy_hold = hold;
      start = 1'b1;
      @(posedge sh_clk); #1;
      start = 1'b0;
      sent = 0; cyc = 0; stall_cyc = 0; en_prev = 0; stalled = 0;
      while (sent < nbits && cyc < 20000) begin
         ch_in_vld = (ign_en || en_prev) && ($urandom_range(99) < vld_pct);
         ch_in = ch_in_vld ? bq[sent] : 1'($urandom_range(1));
         start = (busy_start_at > 0 && sent == busy_start_at);
         if (ch_in_vld) sent++;
         ch_in_done = ch_in_vld && sent == nbits && done_gap == 0;
         if (rel_after > 0 && !stalled && en_prev && !dump_en) begin
            stalled = 1;
            chk("stall_bits", sent, DEPTH * WORD_W + 1);
            chk("stall_vld", word_vld, 1);
            chk("stall_ovf", overflow, 0);
         end
         if (stalled && rdy_hold) begin
            stall_cyc++;
            if (stall_cyc >= rel_after) rdy_hold = 0;
         end
         en_prev = dump_en;
         @(posedge sh_clk); #1;
         cyc++;
         if (abort_at > 0 && sent == abort_at) begin
            ch_in_vld = 0; ch_in_done = 0; start = 0;
            sh_rst = 1;
            @(posedge sh_clk); #1;
            chk("rst_busy", busy, 0);
            chk("rst_vld", word_vld, 0);
            chk("rst_dump_en", dump_en, 0);
            chk("rst_data", word_data, 0);
            chk("rst_nwords", got.size(), 0);
            sh_rst = 0; rdy_hold = 0;
            return;
         end
      end
      chk("drive_tmo", sent, nbits);
      start = 0; ch_in_vld = 0;
      if (done_gap > 0) begin
         repeat (done_gap - 1) begin @(posedge sh_clk); #1; end
         ch_in_done = 1;
         @(posedge sh_clk); #1;
      end
      ch_in_done = 0;
      rdy_hold = 0;
      cyc = 0;
      while (busy && cyc < 5000) begin @(posedge sh_clk); #1; cyc++; end
      chk("drain_tmo", busy, 0);

      nfull = nbits / WORD_W;
      keep  = (hold && ign_en && nfull > DEPTH) ? DEPTH : nfull;
      for (int w = 0; w < keep; w++) begin
         for (int j = 0; j < WORD_W; j++) wv[j] = bq[w * WORD_W + j];
         exp.push_back({1'b0, wv});
      end
      if (nbits % WORD_W != 0) begin
         wv = '0;
         for (int j = 0; j < nbits % WORD_W; j++) wv[j] = bq[nfull * WORD_W + j];
         exp.push_back({1'b0, wv});
      end
      exp.push_back({1'b1, WORD_W'(nbits)});
      chk("nwords", got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk("word", (i < got.size()) ? got[i] : 'x, exp[i]);
      chk("overflow", overflow, keep < nfull);
   endtask

   initial begin
      sh_rst = 1; start = 0; ch_in = 0; ch_in_vld = 0; ch_in_done = 0;
      rdy_hold = 1; rdy_rand = 0;
      repeat (3) @(posedge sh_clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_dump_en", dump_en, 0);
      chk("reset_vld", word_vld, 0);
      chk("reset_last", word_last, 0);
      chk("reset_data", word_data, 0);
      chk("reset_ovf", overflow, 0);
      sh_rst = 0; rdy_hold = 0;
      @(posedge sh_clk); #1;

      run_dump(40, 1, 0, 0, 100, 0, 0, 0, 0);
      if (got.size() == 3) begin
         chk("alt_w0", got[0], {1'b0, 32'h5555_5555});
         chk("alt_w1", got[1], {1'b0, 32'h0000_0055});
         chk("alt_trl", got[2], {1'b1, 32'h0000_0028});
      end
      run_dump(64, 2, 0, 3, 100, 0, 0, 0, 0);
      if (got.size() == 3) chk("ones_trl", got[2], {1'b1, 32'h0000_0040});
      run_dump(320, 0, 0, 0, 100, 5, 0, 0, 1);
      if (got.size() == 11) chk("stall_trl", got[10], {1'b1, 32'h0000_0140});
      run_dump(300, 0, 1, 0, 100, 0, 0, 0, 1);
      chk("ovf_set", overflow, 1);
      if (got.size() == 10) chk("ovf_trl", got[9], {1'b1, 32'h0000_012C});
      run_dump(100, 0, 0, 0, 100, 0, 17, 0, 0);
      run_dump(50, 0, 0, 1, 100, 0, 0, 0, 0);

      got.delete();
      for (int i = 0; i < 5; i++) begin
         ch_in_vld = 1; ch_in_done = 1; ch_in = 1'($urandom_range(1));
         @(posedge sh_clk); #1;
         chk("idle_busy", busy, 0);
      end
      ch_in_vld = 0; ch_in_done = 0;
      repeat (2) begin @(posedge sh_clk); #1; end
      chk("idle_nwords", got.size(), 0);
      chk("idle_vld", word_vld, 0);

      rdy_rand = 1;
      for (int t = 0; t < 12; t++)
         run_dump($urandom_range(1, 150), 0, 0, $urandom_range(0, 3), $urandom_range(40, 100),
                  0, 0, (t == 3) ? 20 : 0, 0);

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
